// File: rtl/uart_pkg.sv
// UART transmit controller shared definitions: FSM state codes,
// line-mux select codes and the optional parity feature flag.
// Macro: UART_TX_PARITY_EN enables the PARITY state.
package uart_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_SYNC   = 3'd1;
    localparam logic [2:0] ST_START  = 3'd2;
    localparam logic [2:0] ST_DATA   = 3'd3;
    localparam logic [2:0] ST_PARITY = 3'd4;
    localparam logic [2:0] ST_STOP   = 3'd5;

    localparam logic [1:0] SEL_START  = 2'b00;
    localparam logic [1:0] SEL_DATA   = 2'b01;
    localparam logic [1:0] SEL_PARITY = 2'b10;
    localparam logic [1:0] SEL_STOP   = 2'b11;

`ifdef UART_TX_PARITY_EN
    localparam bit PARITY_EN = 1'b1;
`else
    localparam bit PARITY_EN = 1'b0;
`endif

    // Line-mux select driven while in a given state.
    function automatic logic [1:0] sel_of(input logic [2:0] st);
        case (st)
            ST_START:  sel_of = SEL_START;
            ST_DATA:   sel_of = SEL_DATA;
            ST_PARITY: sel_of = SEL_PARITY;
            default:   sel_of = SEL_STOP;
        endcase
    endfunction

endpackage

// File: rtl/uart_tx_shreg.sv
// Payload shift register, bit counter and parity generator.
// Ports: clk, rst (sync, active-high), load/shift strobes, din payload;
// data_bit (current LSB), parity_bit, last (final data bit is current).
// Macro: UART_TX_PARITY_EN (via uart_pkg) enables parity, else tied 0.
module uart_tx_shreg
    import uart_pkg::*;
#(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned PARITY_ODD = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              shift,
    input  logic [DATA_W-1:0] din,
    output logic              data_bit,
    output logic              parity_bit,
    output logic              last
);

    localparam int unsigned CW = $clog2(DATA_W);

    logic [DATA_W-1:0] sh;
    logic [CW-1:0]     cnt;
    logic              par;

    always_ff @(posedge clk) begin
        if (rst) begin
            sh  <= '0;
            cnt <= '0;
            par <= 1'b0;
        end else if (load) begin
            sh  <= din;
            cnt <= '0;
            par <= PARITY_EN & (^din ^ 1'(PARITY_ODD));
        end else if (shift) begin
            sh  <= {1'b0, sh[DATA_W-1:1]};
            cnt <= cnt + CW'(1);
        end
    end

    assign data_bit   = sh[0];
    assign parity_bit = par;
    assign last       = (cnt == CW'(DATA_W - 1));

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit frame sequencer driving a registered line-mux select.
// Ports: clk, rst (sync, active-high), baud_tick, tx_start, tx_data;
// mux_sel, data_bit, parity_bit, busy, tx_done.
// Macro: UART_TX_PARITY_EN includes the PARITY state when defined.
module uart_tx_ctrl
    import uart_pkg::*;
#(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned PARITY_ODD = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              baud_tick,
    input  logic              tx_start,
    input  logic [DATA_W-1:0] tx_data,
    output logic [1:0]        mux_sel,
    output logic              data_bit,
    output logic              parity_bit,
    output logic              busy,
    output logic              tx_done
);

    logic [2:0] state;
    logic [2:0] state_nx;
    logic       load;
    logic       shift;
    logic       last;
    logic       stop_cnt;
    logic       stop_last;
    logic       frame_end;

    uart_tx_shreg #(
        .DATA_W     (DATA_W),
        .PARITY_ODD (PARITY_ODD)
    ) u_shreg (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .shift      (shift),
        .din        (tx_data),
        .data_bit   (data_bit),
        .parity_bit (parity_bit),
        .last       (last)
    );

    assign stop_last = (stop_cnt == 1'(STOP_BITS - 1));

    always_comb begin
        state_nx  = state;
        load      = 1'b0;
        shift     = 1'b0;
        frame_end = 1'b0;
        case (state)
            ST_IDLE: begin
                if (tx_start) begin
                    state_nx = ST_SYNC;
                    load     = 1'b1;
                end
            end
            ST_SYNC: begin
                if (baud_tick) state_nx = ST_START;
            end
            ST_START: begin
                if (baud_tick) state_nx = ST_DATA;
            end
            ST_DATA: begin
                if (baud_tick) begin
                    shift = 1'b1;
`ifdef UART_TX_PARITY_EN
                    if (last) state_nx = ST_PARITY;
`else
                    if (last) state_nx = ST_STOP;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (baud_tick) state_nx = ST_STOP;
            end
`endif
            ST_STOP: begin
                if (baud_tick && stop_last) begin
                    state_nx  = ST_IDLE;
                    frame_end = 1'b1;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // mux_sel is derived from the next state so it flips on the
    // same edge as the state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            mux_sel  <= SEL_STOP;
            tx_done  <= 1'b0;
            stop_cnt <= 1'b0;
        end else begin
            state   <= state_nx;
            mux_sel <= sel_of(state_nx);
            tx_done <= frame_end;
            if (state != ST_STOP) begin
                stop_cnt <= 1'b0;
            end else if (baud_tick) begin
                stop_cnt <= ~stop_cnt;
            end
        end
    end

    assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl: even/odd parity, 1 and 2 stop bits,
// ignored start, mid-frame reset, coincident tick, back-to-back frames.
module tb_uart_tx_ctrl;

    localparam int DW = 8;
`ifdef UART_TX_PARITY_EN
    localparam int PEN = 1;
`else
    localparam int PEN = 0;
`endif
    localparam int N0 = 2 + DW + PEN + 1;
    localparam int N2 = N0 + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          baud_tick = 1'b0;
    logic          tx_start = 1'b0;
    logic [DW-1:0] tx_data = '0;
    logic          hold = 1'b0;

    logic [1:0] sel0, sel1, sel2;
    logic       db0, db1, db2;
    logic       pb0, pb1, pb2;
    logic       bz0, bz1, bz2;
    logic       dn0, dn1, dn2;

    int vectors = 0;
    int miscompares = 0;
    int done0 = 0;
    int done2 = 0;

    always #5 clk = ~clk;

    uart_tx_ctrl #(.DATA_W(DW), .STOP_BITS(1), .PARITY_ODD(0)) dut0 (
        .clk(clk), .rst(rst), .baud_tick(baud_tick),
        .tx_start(tx_start), .tx_data(tx_data),
        .mux_sel(sel0), .data_bit(db0), .parity_bit(pb0),
        .busy(bz0), .tx_done(dn0)
    );

    uart_tx_ctrl #(.DATA_W(DW), .STOP_BITS(1), .PARITY_ODD(1)) dut1 (
        .clk(clk), .rst(rst), .baud_tick(baud_tick),
        .tx_start(tx_start), .tx_data(tx_data),
        .mux_sel(sel1), .data_bit(db1), .parity_bit(pb1),
        .busy(bz1), .tx_done(dn1)
    );

    uart_tx_ctrl #(.DATA_W(DW), .STOP_BITS(2), .PARITY_ODD(0)) dut2 (
        .clk(clk), .rst(rst), .baud_tick(baud_tick),
        .tx_start(tx_start), .tx_data(tx_data),
        .mux_sel(sel2), .data_bit(db2), .parity_bit(pb2),
        .busy(bz2), .tx_done(dn2)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    function automatic logic [1:0] exp_sel(input int k);
        if (k == 1) return 2'b00;
        if (k <= DW + 1) return 2'b01;
        if (PEN != 0 && k == DW + 2) return 2'b10;
        return 2'b11;
    endfunction

    task automatic clk1(input logic t, input logic s);
        baud_tick = t;
        tx_start  = s | hold;
        @(posedge clk);
        #1;
        baud_tick = 1'b0;
        tx_start  = hold;
        if (dn0) done0++;
        if (dn2) done2++;
    endtask

    task automatic bit_period(input bit inj);
        logic [DW-1:0] keep;
        for (int c = 0; c < 15; c++) begin
            if (inj && c == 7) begin
                keep    = tx_data;
                tx_data = 8'hFF;
                clk1(1'b0, 1'b1);
                tx_data = keep;
            end else begin
                clk1(1'b0, 1'b0);
            end
        end
        clk1(1'b1, 1'b0);
    endtask

    task automatic accept(input logic [DW-1:0] d, input logic coinc);
        tx_data = d;
        clk1(coinc, 1'b1);
        check("acc_busy0", bz0, 1);
        check("acc_sel0", sel0, 2'b11);
        check("acc_par0", pb0, (PEN != 0) && (^d));
        check("acc_par1", pb1, (PEN != 0) && !(^d));
        check("acc_busy2", bz2, 1);
    endtask

    task automatic run(input logic [DW-1:0] d, input int inj_k,
                       input bit chk2, input int nt);
        done0 = 0;
        done2 = 0;
        for (int k = 1; k <= nt; k++) begin
            bit_period(k == inj_k);
            if (k <= N0) begin
                check($sformatf("sel0_k%0d", k), sel0, exp_sel(k));
                check($sformatf("sel1_k%0d", k), sel1, exp_sel(k));
                check($sformatf("busy0_k%0d", k), bz0, k < N0);
                check($sformatf("done0_k%0d", k), dn0, k == N0);
                check($sformatf("done1_k%0d", k), dn1, k == N0);
                if (exp_sel(k) == 2'b01) begin
                    check($sformatf("db0_k%0d", k), db0, d[k-2]);
                    check($sformatf("db1_k%0d", k), db1, d[k-2]);
                end
                if (k < N0) begin
                    check($sformatf("par0_k%0d", k), pb0,
                          (PEN != 0) && (^d));
                end
            end
            if (chk2) begin
                check($sformatf("sel2_k%0d", k), sel2, exp_sel(k));
                check($sformatf("busy2_k%0d", k), bz2, k < N2);
                check($sformatf("done2_k%0d", k), dn2, k == N2);
                if (exp_sel(k) == 2'b01) begin
                    check($sformatf("db2_k%0d", k), db2, d[k-2]);
                end
                if (k < N2) begin
                    check($sformatf("par2_k%0d", k), pb2,
                          (PEN != 0) && (^d));
                end
            end
        end
        if (nt >= N0) check("done0_cnt", done0, 1);
        if (chk2) check("done2_cnt", done2, 1);
    endtask

    task automatic idle_chk(input string tag);
        bit_period(1'b0);
        check({tag, "_sel0"}, sel0, 2'b11);
        check({tag, "_busy0"}, bz0, 0);
        check({tag, "_sel2"}, sel2, 2'b11);
        check({tag, "_busy2"}, bz2, 0);
    endtask

    initial begin
        rst = 1'b1;
        clk1(1'b0, 1'b0);
        clk1(1'b0, 1'b1);
        check("rst_sel0", sel0, 2'b11);
        check("rst_db0", db0, 0);
        check("rst_par0", pb0, 0);
        check("rst_par1", pb1, 0);
        check("rst_busy0", bz0, 0);
        check("rst_done0", dn0, 0);
        check("rst_busy2", bz2, 0);
        rst = 1'b0;

        // 0xA5 frame with the full per-tick sequence
        accept(8'hA5, 1'b0);
        run(8'hA5, 0, 1'b1, N2);
        idle_chk("a5_idle");

        // single set bit: parity differs between even and odd units
        accept(8'h01, 1'b0);
        run(8'h01, 0, 1'b1, N2);
        idle_chk("p01_idle");

        // start pulsed during data bit 3 is ignored
        accept(8'hC3, 1'b0);
        run(8'hC3, 6, 1'b1, N2);
        idle_chk("ign_idle");
        check("ign_done0", done0, 1);
        check("ign_done2", done2, 1);

        // reset during data bit 5, with a start pending
        accept(8'h5A, 1'b0);
        run(8'h5A, 0, 1'b0, 7);
        clk1(1'b0, 1'b0);
        clk1(1'b0, 1'b0);
        rst = 1'b1;
        clk1(1'b0, 1'b1);
        rst = 1'b0;
        check("mrst_sel0", sel0, 2'b11);
        check("mrst_busy0", bz0, 0);
        check("mrst_done0", dn0, 0);
        check("mrst_db0", db0, 0);
        check("mrst_par1", pb1, 0);
        check("mrst_busy2", bz2, 0);
        clk1(1'b0, 1'b0);
        check("mrst_drop0", bz0, 0);
        done0 = 0;
        done2 = 0;
        for (int i = 0; i < N2; i++) bit_period(1'b0);
        check("mrst_nodone0", done0, 0);
        check("mrst_nodone2", done2, 0);
        check("mrst_idle0", sel0, 2'b11);

        // clean frame after reset; 0x3C exercises two stop bits
        accept(8'h3C, 1'b0);
        run(8'h3C, 0, 1'b1, N2);
        idle_chk("c3c_idle");

        // start coincident with a tick: START only on the next tick
        accept(8'h5A, 1'b1);
        run(8'h5A, 0, 1'b1, N2);
        idle_chk("coin_idle");

        // start held through tx_done: second frame follows directly
        hold = 1'b1;
        accept(8'hC3, 1'b0);
        run(8'hC3, 0, 1'b0, N0);
        tx_data = 8'h96;
        clk1(1'b0, 1'b0);
        hold = 1'b0;
        check("b2b_busy0", bz0, 1);
        check("b2b_sel0", sel0, 2'b11);
        check("b2b_par0", pb0, (PEN != 0) && (^tx_data));
        run(8'h96, 0, 1'b0, N0);
        idle_chk("b2b_idle");

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
